flow_light_ctrl: RTL and testbench
==================================

# flow_light_ctrl

Sequencing controller for the 16-LED flowing-light datapath. It divides the board clock into pattern steps, selects one of four light patterns, and handles run/hold from the board switch. It also generates the next 16-bit LED word each step. It sits between the board switch inputs and the `led[15:0]` pins and replaces the free-running shift register as the owner of the LED word.

## Interface
Parameters:
- `DIV`, default 25_000_000: clock cycles per pattern step; legal range ≥ 2. Benches use 4.
- `DIV_W`, default 25: width of the prescaler counter; must satisfy 2^DIV_W > DIV.

Ports:
- `CLK` (in, 1): single system clock, rising edge.
- `reset` (in, 1): synchronous, active-low reset.
- `SW_in` (in, 1): run switch, asynchronous level; 1 = run, 0 = hold.
- `mode` (in, 2): pattern select.
  - 0 = rotate-left
  - 1 = rotate-right
  - 2 = bounce
  - 3 = fill/drain
- `led` (out, 16): LED word, registered.
- `step` (out, 1): one-cycle pulse, asserted in the cycle in which `led` shows a newly stepped or reloaded value.

## Operation
- `SW_in` passes through a 2-flop synchronizer, producing `sw_s`. `mode` is registered once, producing `mode_q`, which is used for change detection.
- FSM states:
  - IDLE → RUN when `sw_s`=1: load `led` with the seed for the current `mode` and clear the prescaler. `step` is not pulsed.
  - RUN → HOLD when `sw_s`=0: prescaler and `led` freeze.
  - HOLD → RUN when `sw_s`=1: the prescaler resumes from its frozen count; the pattern is not reloaded.
- Seeds: mode 0 = 0x0001; mode 1 = 0x8000; mode 2 = 0x0001 with `dir`=left; mode 3 = 0x0000 with `phase`=fill.
- Step event: in RUN with `cnt`==DIV-1, `cnt` returns to 0, `led` advances, and `step` is 1 in the following cycle.
- Advance rules per mode:
  - 0: rotate left by 1 bit; 0x8000 → 0x0001.
  - 1: rotate right by 1 bit; 0x0001 → 0x8000.
  - 2 (bounce): single lit bit moving.
    - If `dir`=left and `led`=0x8000: set `dir`=right, next `led` = 0x4000.
    - If `dir`=right and `led`=0x0001: set `dir`=left, next `led` = 0x0002.
    - Otherwise shift one bit in `dir`.
    - Period is 30 steps.
  - 3 (fill/drain):
    - phase=fill: `led` = {`led`[14:0],1}; when `led`=0xFFFF, switch to drain.
    - phase=drain: `led` = {`led`[14:0],0}; when `led`=0x0000, switch to fill.
    - Period is 32 steps.
- Mode change: if `mode`≠`mode_q` is seen in RUN or HOLD, set the `reload` flag. At the next step event, `led` loads the new mode's seed instead of advancing. `step` still pulses and `reload` clears. The prescaler is not reset on a mode change.
- Mode change together with a step event in the same cycle: the step advances under the old mode and `reload` is set for the following step.

## Timing
- Reset values (the cycle after the `CLK` edge with `reset`=0): state = IDLE, `led` = 0x0000, `step` = 0, `cnt` = 0, `dir` = left, `phase` = fill, `reload` = 0, synchronizer flops = 0.
- `reset` has priority over every other event. Asserting it mid-RUN returns all values to reset values at the next edge.
- `SW_in` latency: a `SW_in` edge affects state 3 edges later (2 synchronizer edges, then 1 FSM edge).
- First step: with RUN entered at edge E0 (cnt=0), `led` changes at E0+DIV, E0+2·DIV, and so on.
- HOLD time does not count toward DIV: the step spacing across a hold is DIV cycles of RUN time.
- `step` is never high for 2 consecutive cycles, because DIV ≥ 2.
- Illegal state encodings recover to IDLE.

## Structure
- Shared package `flow_light_pkg` holds:
  - `LED_W`=16.
  - Mode encodings `MODE_ROTL`, `MODE_ROTR`, `MODE_BOUNCE`, `MODE_FILL`.
  - FSM state typedef (IDLE, RUN, HOLD).
  - Seed constants per mode.
- One sub-module, `flow_prescaler`: parameterized by DIV/DIV_W, with `en` input, `clr` input, `tick` output, and the same synchronous active-low `reset`.
- Pattern next-state logic, the FSM and the synchronizer live in `flow_light_ctrl`.

## Test plan
All scenarios use DIV=4.
- Reset and start: hold `reset`=0 for 3 cycles → `led`=0x0000, `step`=0. Release with `mode`=0 and `SW_in`=1 → `led`=0x0001 three edges after the switch. Then 0x0002, 0x0004, … every 4 cycles; 0x8000 is followed by 0x0001.
- Bounce: `mode`=2, run 40 steps → sequence 0x0001…0x8000, 0x4000…0x0001, 0x0002. No word has 0 or 2 bits set. Period is 30 steps.
- Fill/drain: `mode`=3 → 0x0000, 0x0001, 0x0003 … 0xFFFF, 0xFFFE … 0x8000, 0x0000. Period is 32 steps.
- Hold/resume: drop `SW_in` mid-count at cnt=2, hold for 50 cycles, then raise it → `led` frozen throughout the hold. The next step arrives 2 RUN cycles after resume, plus synchronizer latency.
- Mode change: in mode 0 at `led`=0x0010, switch to mode 1 → the next step shows 0x8000 (the seed) with `step`=1, then 0x4000.
- Reset mid-run: assert `reset` during mode 2 with `dir`=right → next cycle state = IDLE, `led`=0x0000. After restart in mode 2, bounce begins leftward from 0x0001.

Source files
------------

// File: rtl/flow_light_pkg.sv
// Shared types and constants for the flowing-light sequencer.
// Covers LED width, pattern mode encodings, FSM states and per-mode seeds.
package flow_light_pkg;

    localparam int unsigned LED_W = 16;

    localparam logic [1:0] MODE_ROTL   = 2'd0;
    localparam logic [1:0] MODE_ROTR   = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_FILL   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    typedef enum logic {
        PH_FILL  = 1'b0,
        PH_DRAIN = 1'b1
    } phase_e;

    localparam logic [LED_W-1:0] SEED_ROTL   = LED_W'(16'h0001);
    localparam logic [LED_W-1:0] SEED_ROTR   = LED_W'(16'h8000);
    localparam logic [LED_W-1:0] SEED_BOUNCE = LED_W'(16'h0001);
    localparam logic [LED_W-1:0] SEED_FILL   = LED_W'(16'h0000);

    localparam logic [LED_W-1:0] LED_TOP = LED_W'(16'h8000);
    localparam logic [LED_W-1:0] LED_BOT = LED_W'(16'h0001);

    function automatic logic [LED_W-1:0] seed_for(input logic [1:0] m);
        logic [LED_W-1:0] s;
        case (m)
            MODE_ROTL:   s = SEED_ROTL;
            MODE_ROTR:   s = SEED_ROTR;
            MODE_BOUNCE: s = SEED_BOUNCE;
            default:     s = SEED_FILL;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/flow_prescaler.sv
// Step prescaler: counts enabled cycles and flags the last cycle of each
// DIV-cycle period; the count is held while disabled.
module flow_prescaler #(
    parameter int unsigned DIV   = 25_000_000,
    parameter int unsigned DIV_W = 25
) (
    input  logic CLK,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_W-1:0] CNT_MAX = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/flow_light_ctrl.sv
// Flowing-light sequencer: run/hold FSM, switch synchronizer, pattern
// generation for four modes and deferred reload on mode change.
module flow_light_ctrl
    import flow_light_pkg::*;
#(
    parameter int unsigned DIV   = 25_000_000,
    parameter int unsigned DIV_W = 25
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             SW_in,
    input  logic [1:0]       mode,
    output logic [LED_W-1:0] led,
    output logic             step
);

    logic             sw_meta_q, sw_s_q;
    logic [1:0]       mode_q;
    state_e           state_q, state_d;
    logic [LED_W-1:0] led_q, led_d, adv_led;
    dir_e             dir_q, dir_d, adv_dir;
    phase_e           phase_q, phase_d, adv_phase;
    logic             reload_q, reload_d;
    logic             step_q, step_d;
    logic             pre_en, pre_clr, tick;
    logic             mode_chg;

    // Two-flop synchronizer for the switch; mode registered for change detect
    always_ff @(posedge CLK) begin
        if (!reset) begin
            sw_meta_q <= 1'b0;
            sw_s_q    <= 1'b0;
            mode_q    <= MODE_ROTL;
        end else begin
            sw_meta_q <= SW_in;
            sw_s_q    <= sw_meta_q;
            mode_q    <= mode;
        end
    end

    assign pre_en   = (state_q == ST_RUN);
    assign pre_clr  = (state_q == ST_IDLE) && sw_s_q;
    assign mode_chg = (mode != mode_q);

    flow_prescaler #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_prescaler (
        .CLK   (CLK),
        .reset (reset),
        .en    (pre_en),
        .clr   (pre_clr),
        .tick  (tick)
    );

    // Next pattern word under the registered mode
    always_comb begin
        adv_led   = led_q;
        adv_dir   = dir_q;
        adv_phase = phase_q;
        case (mode_q)
            MODE_ROTL: adv_led = {led_q[LED_W-2:0], led_q[LED_W-1]};
            MODE_ROTR: adv_led = {led_q[0], led_q[LED_W-1:1]};
            MODE_BOUNCE: begin
                if (dir_q == DIR_LEFT) begin
                    if (led_q == LED_TOP) begin
                        adv_dir = DIR_RIGHT;
                        adv_led = LED_TOP >> 1;
                    end else begin
                        adv_led = led_q << 1;
                    end
                end else begin
                    if (led_q == LED_BOT) begin
                        adv_dir = DIR_LEFT;
                        adv_led = LED_BOT << 1;
                    end else begin
                        adv_led = led_q >> 1;
                    end
                end
            end
            default: begin
                if ((phase_q == PH_FILL) && (led_q == '1)) begin
                    adv_phase = PH_DRAIN;
                end else if ((phase_q == PH_DRAIN) && (led_q == '0)) begin
                    adv_phase = PH_FILL;
                end
                adv_led = {led_q[LED_W-2:0], (adv_phase == PH_FILL)};
            end
        endcase
    end

    // FSM next-state and pattern register updates
    always_comb begin
        state_d  = state_q;
        led_d    = led_q;
        dir_d    = dir_q;
        phase_d  = phase_q;
        reload_d = reload_q;
        step_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sw_s_q) begin
                    state_d  = ST_RUN;
                    led_d    = seed_for(mode);
                    dir_d    = DIR_LEFT;
                    phase_d  = PH_FILL;
                    reload_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (!sw_s_q) begin
                    state_d = ST_HOLD;
                end
                if (tick) begin
                    step_d   = 1'b1;
                    reload_d = mode_chg;
                    if (reload_q) begin
                        led_d   = seed_for(mode_q);
                        dir_d   = DIR_LEFT;
                        phase_d = PH_FILL;
                    end else begin
                        led_d   = adv_led;
                        dir_d   = adv_dir;
                        phase_d = adv_phase;
                    end
                end else begin
                    reload_d = reload_q | mode_chg;
                end
            end
            ST_HOLD: begin
                if (sw_s_q) begin
                    state_d = ST_RUN;
                end
                reload_d = reload_q | mode_chg;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            led_q    <= '0;
            dir_q    <= DIR_LEFT;
            phase_q  <= PH_FILL;
            reload_q <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            led_q    <= led_d;
            dir_q    <= dir_d;
            phase_q  <= phase_d;
            reload_q <= reload_d;
            step_q   <= step_d;
        end
    end

    assign led  = led_q;
    assign step = step_q;

endmodule

// File: tb/tb_flow_light_ctrl.sv
// Directed bench for flow_light_ctrl with DIV=4: start-up latency, all four
// patterns, hold/resume, mode-change reload and reset mid-run.
module tb_flow_light_ctrl;

    logic        CLK;
    logic        reset;
    logic        SW_in;
    logic [1:0]  mode;
    logic [15:0] led;
    logic        step;

    int          tests;
    int          fails;
    int          pos;
    int          kk;
    bit          right;
    logic [15:0] exp_led;

    flow_light_ctrl #(
        .DIV   (4),
        .DIV_W (3)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .SW_in (SW_in),
        .mode  (mode),
        .led   (led),
        .step  (step)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_step(input string tag, input logic [15:0] exp);
        check({tag, "_led"}, led, exp);
        check({tag, "_step"}, 16'(step), 16'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        SW_in = 1'b0;
        cyc(3);
        check("rst_led", led, 16'h0000);
        check("rst_step", 16'(step), 16'd0);
        reset = 1'b1;
    endtask

    // Raise the switch and expect the seed exactly three edges later
    task automatic start(input logic [1:0] m, input logic [15:0] seed, input string tag);
        mode  = m;
        SW_in = 1'b1;
        cyc(2);
        check({tag, "_pre_seed"}, led, 16'h0000);
        cyc(1);
        check({tag, "_seed"}, led, seed);
        check({tag, "_seed_nostep"}, 16'(step), 16'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        SW_in = 1'b0;
        mode  = 2'd0;
        cyc(1);

        // Rotate-left from reset, full wrap
        do_reset();
        start(2'd0, 16'h0001, "rotl");
        cyc(3);
        check("rotl_before_step", led, 16'h0001);
        cyc(1);
        check_step("rotl_1", 16'h0002);
        cyc(1);
        check("rotl_step_single", 16'(step), 16'd0);
        cyc(3);
        for (int k = 2; k <= 16; k++) begin
            exp_led = 16'(32'd1 << (k % 16));
            check_step($sformatf("rotl_%0d", k), exp_led);
            if (k < 16) cyc(4);
        end

        // Bounce: 40 steps against a position/direction model
        do_reset();
        start(2'd2, 16'h0001, "bnc");
        pos   = 0;
        right = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (!right && pos == 15) begin
                right = 1'b1;
                pos   = 14;
            end else if (right && pos == 0) begin
                right = 1'b0;
                pos   = 1;
            end else begin
                pos = right ? pos - 1 : pos + 1;
            end
            exp_led = 16'(32'd1 << pos);
            cyc(4);
            check($sformatf("bnc_%0d", k), led, exp_led);
            check($sformatf("bnc_ones_%0d", k), 16'($countones(led)), 16'd1);
        end

        // Fill/drain: 33 steps covering one full period plus wrap
        do_reset();
        start(2'd3, 16'h0000, "fill");
        for (int k = 1; k <= 33; k++) begin
            kk = ((k - 1) % 32) + 1;
            if (kk <= 16) exp_led = 16'((32'd1 << kk) - 32'd1);
            else          exp_led = 16'(32'h0000_FFFF << (kk - 16));
            cyc(4);
            check($sformatf("fill_%0d", k), led, exp_led);
        end

        // Hold/resume: freeze at cnt=2, resume two RUN cycles short of a step
        do_reset();
        start(2'd0, 16'h0001, "hold");
        cyc(3);
        SW_in = 1'b0;
        cyc(1);
        check_step("hold_pre", 16'h0002);
        cyc(25);
        check("hold_mid_led", led, 16'h0002);
        check("hold_mid_step", 16'(step), 16'd0);
        cyc(25);
        check("hold_end_led", led, 16'h0002);
        SW_in = 1'b1;
        cyc(4);
        check("resume_wait_led", led, 16'h0002);
        check("resume_wait_step", 16'(step), 16'd0);
        cyc(1);
        check_step("resume_1", 16'h0004);
        cyc(4);
        check_step("resume_2", 16'h0008);

        // Mode change mid-period reloads the new seed at the next step
        do_reset();
        start(2'd0, 16'h0001, "mchg");
        cyc(16);
        check_step("mchg_0x10", 16'h0010);
        mode = 2'd1;
        cyc(1);
        check("mchg_no_immediate", led, 16'h0010);
        cyc(3);
        check_step("mchg_seed", 16'h8000);
        cyc(4);
        check_step("mchg_rotr", 16'h4000);
        // Change coincident with a step: advance under old mode, then reload
        cyc(3);
        mode = 2'd3;
        cyc(1);
        check_step("mcoin_old_adv", 16'h2000);
        cyc(4);
        check_step("mcoin_seed", 16'h0000);
        cyc(4);
        check_step("mcoin_fill", 16'h0001);

        // Reset mid-run while bouncing rightward, then restart leftward
        do_reset();
        start(2'd2, 16'h0001, "rmid");
        cyc(80);
        check_step("rmid_right", 16'h0400);
        cyc(2);
        reset = 1'b0;
        cyc(1);
        check("rmid_reset_led", led, 16'h0000);
        check("rmid_reset_step", 16'(step), 16'd0);
        reset = 1'b1;
        cyc(2);
        check("rmid_idle_led", led, 16'h0000);
        cyc(1);
        check("rmid_reseed", led, 16'h0001);
        cyc(4);
        check_step("rmid_left_1", 16'h0002);
        cyc(4);
        check_step("rmid_left_2", 16'h0004);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
